// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle MUL / DIVU / REMU sequencer that borrows the execute-stage ALU
// for its add/subtract steps; shift-add multiply and restoring divide.
module alu_muldiv_sequencer #(
    parameter logic [4:0] ALU_ADD  = 5'd3,
    parameter logic [4:0] ALU_SUB  = 5'd4,
    parameter logic [4:0] ALU_ZERO = 5'd31,
    parameter int         STEPS    = 32
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iStart,
    input  logic [1:0]  iOp,
    input  logic [31:0] iOpA,
    input  logic [31:0] iOpB,
    output logic [4:0]  oAluControl,
    output logic [31:0] oAluA,
    output logic [31:0] oAluB,
    input  logic [31:0] iAluResult,
    output logic        oBusy,
    output logic        oDone,
    output logic [31:0] oResult
);

    typedef enum logic [1:0] {S_IDLE, S_STEP, S_DONE} state_t;

    localparam logic [1:0] OP_MUL  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_REMU = 2'd2;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] work_q, work_d;     // acc (MUL) or rem (DIVU/REMU)
    logic [31:0] a_q, a_d;           // mcand (MUL) or quo (DIVU/REMU)
    logic [31:0] b_q, b_d;           // mplier (MUL) or div (DIVU/REMU)
    logic [31:0] result_q, result_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [31:0] t;
    logic        hi, borrow, ge, last;

    // Shifted remainder {hi, t}; ge decides whether the trial subtract is kept.
    assign t      = {work_q[30:0], a_q[31]};
    assign hi     = work_q[31];
    assign borrow = (~t[31] & b_q[31]) | (~(t[31] ^ b_q[31]) & iAluResult[31]);
    assign ge     = hi | ~borrow;
    assign last   = (cnt_q == 5'(STEPS - 1));

    always_comb begin
        oAluControl = ALU_ZERO;
        oAluA       = '0;
        oAluB       = '0;
        if (state_q == S_STEP) begin
            case (op_q)
                OP_MUL: begin
                    oAluControl = ALU_ADD;
                    oAluA       = work_q;
                    oAluB       = b_q[0] ? a_q : '0;
                end
                OP_DIVU, OP_REMU: begin
                    oAluControl = ALU_SUB;
                    oAluA       = t;
                    oAluB       = b_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    op_d    = iOp;
                    cnt_d   = '0;
                    work_d  = '0;
                    a_d     = iOpA;
                    b_d     = iOpB;
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                cnt_d = cnt_q + 5'd1;
                case (op_q)
                    OP_MUL: begin
                        work_d = iAluResult;
                        a_d    = a_q << 1;
                        b_d    = b_q >> 1;
                    end
                    OP_DIVU, OP_REMU: begin
                        work_d = ge ? iAluResult : t;
                        a_d    = {a_q[30:0], ge};
                    end
                    default: ;
                endcase
                if (last) begin
                    state_d = S_DONE;
                    case (op_q)
                        OP_MUL:  result_d = iAluResult;
                        OP_DIVU: result_d = {a_q[30:0], ge};
                        OP_REMU: result_d = ge ? iAluResult : t;
                        default: result_d = '0;
                    endcase
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            work_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign oBusy   = busy_q;
    assign oDone   = done_q;
    assign oResult = result_q;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Bench for alu_muldiv_sequencer: models the ALU, queues expected results at
// start and compares them when oDone fires.
module tb_alu_muldiv_sequencer;

  logic        iCLK   = 1'b0;
  logic        iRST_n = 1'b0;
  logic        iStart = 1'b0;
  logic [1:0]  iOp    = 2'd0;
  logic [31:0] iOpA   = '0;
  logic [31:0] iOpB   = '0;
  logic [4:0]  oAluControl;
  logic [31:0] oAluA, oAluB, iAluResult, oResult;
  logic        oBusy, oDone;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = '0;

  alu_muldiv_sequencer dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iStart(iStart), .iOp(iOp),
    .iOpA(iOpA), .iOpB(iOpB), .oAluControl(oAluControl),
    .oAluA(oAluA), .oAluB(oAluB), .iAluResult(iAluResult),
    .oBusy(oBusy), .oDone(oDone), .oResult(oResult)
  );

  always #5 iCLK = ~iCLK;

  // Execute-stage ALU stand-in
  always_comb begin
    iAluResult = '0;
    if (oAluControl == 5'd3) iAluResult = oAluA + oAluB;
    else if (oAluControl == 5'd4) iAluResult = oAluA - oAluB;
  end

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      2'd0:    return p[31:0];
      2'd1:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2:    return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit inject, input string name);
    int cyc;
    int extra;
    logic [31:0] exp_v;
    logic [4:0]  exp_ctl;
    @(negedge iCLK);
    iStart = 1'b1; iOp = op; iOpA = a; iOpB = b;
    exp_q.push_back(model(op, a, b));
    @(negedge iCLK);
    iStart = 1'b0;
    cyc = 0;
    checks++;
    if (oBusy !== 1'b1 || oResult !== last_res) begin
      errors++;
      $display("FAIL %s start: busy=%b result=%h, expected busy=1 result=%h", name, oBusy, oResult, last_res);
    end
    exp_ctl = (op == 2'd0) ? 5'd3 : (op == 2'd3) ? 5'd31 : 5'd4;
    checks++;
    if (oAluControl !== exp_ctl) begin
      errors++;
      $display("FAIL %s alu_ctl: got %0d expected %0d", name, oAluControl, exp_ctl);
    end
    while (oDone !== 1'b1 && cyc < 40) begin
      @(negedge iCLK);
      cyc++;
      if (inject && cyc == 10) begin
        iStart = 1'b1; iOp = op ^ 2'd1; iOpA = ~a; iOpB = b + 32'd1;
      end
      if (inject && cyc == 11) iStart = 1'b0;
    end
    iStart = 1'b0;
    checks++;
    if (cyc != 32) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles expected 32", name, cyc);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (oResult !== exp_v) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", name, oResult, exp_v);
    end
    last_res = exp_v;
    if (inject) begin
      iStart = 1'b1; iOp = 2'd0; iOpA = 32'd3; iOpB = 32'd5;
    end
    @(negedge iCLK);
    iStart = 1'b0;
    checks++;
    if (oBusy !== 1'b0 || oDone !== 1'b0 || oAluControl !== 5'd31 || oAluA !== 32'd0 || oAluB !== 32'd0) begin
      errors++;
      $display("FAIL %s idle: busy=%b done=%b ctl=%0d a=%h b=%h expected 0/0/31/0/0",
               name, oBusy, oDone, oAluControl, oAluA, oAluB);
    end
    if (inject) begin
      extra = 0;
      repeat (40) begin
        @(negedge iCLK);
        if (oDone === 1'b1 || oBusy === 1'b1) extra++;
      end
      checks++;
      if (extra != 0 || oResult !== last_res) begin
        errors++;
        $display("FAIL %s ignored_start: extra busy/done cycles=%0d result=%h expected 0 and %h",
                 name, extra, oResult, last_res);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (oBusy !== 1'b0 || oDone !== 1'b0 || oResult !== 32'd0 || oAluControl !== 5'd31 || oAluA !== 32'd0 || oAluB !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b res=%h ctl=%0d a=%h b=%h expected all 0, ctl=31",
               oBusy, oDone, oResult, oAluControl, oAluA, oAluB);
    end
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    iRST_n = 1'b1;
    @(negedge iCLK);
    checks++;
    if (oBusy !== 1'b0 || oDone !== 1'b0 || oResult !== 32'd0) begin
      errors++;
      $display("FAIL reset_release: busy=%b done=%b res=%h expected 0/0/0", oBusy, oDone, oResult);
    end
  endtask

  task automatic test_mul();
    do_op(2'd0, 32'd7, 32'd6, 1'b0, "mul_7x6");
    do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mul_ones");
    do_op(2'd0, 32'h8000_0000, 32'd2, 1'b0, "mul_overflow");
  endtask

  task automatic test_div();
    do_op(2'd1, 32'd100, 32'd7, 1'b0, "divu_100_7");
    do_op(2'd2, 32'd100, 32'd7, 1'b0, "remu_100_7");
    do_op(2'd1, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, "divu_signbit");
    do_op(2'd2, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, "remu_signbit");
  endtask

  task automatic test_div_zero();
    do_op(2'd1, 32'h1234_5678, 32'd0, 1'b0, "divu_zero");
    do_op(2'd2, 32'h1234_5678, 32'd0, 1'b0, "remu_zero");
    do_op(2'd3, 32'hDEAD_BEEF, 32'd9, 1'b0, "op_reserved");
  endtask

  task automatic test_busy();
    do_op(2'd1, 32'd1000, 32'd33, 1'b1, "busy_divu");
    do_op(2'd0, 32'd7, 32'd6, 1'b1, "busy_mul");
  endtask

  task automatic test_reset_mid();
    int dn;
    @(negedge iCLK);
    iStart = 1'b1; iOp = 2'd0; iOpA = 32'h0001_2345; iOpB = 32'h0000_0777;
    exp_q.push_back(model(2'd0, 32'h0001_2345, 32'h0000_0777));
    @(negedge iCLK);
    iStart = 1'b0;
    repeat (9) @(negedge iCLK);
    #2 iRST_n = 1'b0;
    #1;
    checks++;
    if (oBusy !== 1'b0 || oDone !== 1'b0 || oResult !== 32'd0 || oAluControl !== 5'd31 || oAluA !== 32'd0 || oAluB !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b res=%h ctl=%0d a=%h b=%h expected all 0, ctl=31",
               oBusy, oDone, oResult, oAluControl, oAluA, oAluB);
    end
    exp_q.delete();
    last_res = '0;
    repeat (3) @(negedge iCLK);
    iRST_n = 1'b1;
    dn = 0;
    repeat (40) begin
      @(negedge iCLK);
      if (oDone === 1'b1 || oBusy === 1'b1) dn++;
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL reset_abandon: busy/done cycles after reset=%0d expected 0", dn);
    end
    do_op(2'd0, 32'h0001_2345, 32'h0000_0777, 1'b0, "restart_mul");
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 6; i++) begin
      op = 2'($urandom_range(0, 2));
      a  = $urandom;
      b  = (i == 5) ? 32'($urandom_range(1, 255)) : $urandom;
      do_op(op, a, b, 1'b0, "random");
    end
  endtask

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_busy();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
